pwm12_decoder: RTL and testbench

Measures the complementary, non-overlapped PWM pair produced by the team's 12-bit motor PWM generator. It recovers the commanded 12-bit duty and the PWM period, and flags overlap and dead-time faults. It sits on the receive side of the motor-drive interface as a self-check and monitor: on the board-level bench it observes the driver outputs, and in silicon it feeds the fault logic.

---
 rtl/pwm12_decoder.sv | 130 +++++++++++++
 tb/tb_pwm12_decoder.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm12_decoder.sv
// Recovers duty and period from the complementary PWM1/PWM2 pair and flags overlap and dead-time faults.
// Outputs update one clock after a synchronised edge is seen; no backpressure, meas_vld is a single-cycle pulse.
module pwm12_decoder #(
  parameter logic [11:0] NONOVERLAP = 12'h02C,
  parameter int          MIN_GAP    = 8,
  parameter logic [12:0] TIMEOUT    = 13'h1FFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        PWM1,
  input  logic        PWM2,
  input  logic        clr_err,
  output logic [11:0] duty_meas,
  output logic [12:0] period_meas,
  output logic        meas_vld,
  output logic        overlap_err,
  output logic        gap_err,
  output logic        stalled
);

  localparam logic [1:0]  IDLE    = 2'd0;
  localparam logic [1:0]  HIGH    = 2'd1;
  localparam logic [1:0]  LOW     = 2'd2;
  localparam logic [3:0]  GAP_LIM = 4'(MIN_GAP - 1);
  localparam logic [12:0] CNT_MAX = 13'h1FFF;

  // [0] and [1] form the synchroniser, [2] is the edge-detect delay
  logic [2:0]  p1_sh, p2_sh;
  logic        p1, p1_d, p2, p2_d;
  logic        p1_rise, p1_fall, p2_rise, p2_fall;
  logic [1:0]  state;
  logic [12:0] period_cnt, high_cnt;
  logic [3:0]  gap_cnt;
  logic        gap_armed, timeout, gap_evt;
  logic [13:0] duty_sum;
  logic [11:0] duty_clamp;

  assign p1      = p1_sh[1];
  assign p1_d    = p1_sh[2];
  assign p2      = p2_sh[1];
  assign p2_d    = p2_sh[2];
  assign p1_rise = p1 & ~p1_d;
  assign p1_fall = ~p1 & p1_d;
  assign p2_rise = p2 & ~p2_d;
  assign p2_fall = ~p2 & p2_d;

  assign timeout    = (state != IDLE) && (period_cnt == TIMEOUT);
  assign gap_evt    = (p1_rise | p2_rise) & gap_armed & (gap_cnt < GAP_LIM);
  assign duty_sum   = {1'b0, high_cnt} + {2'b00, NONOVERLAP};
  assign duty_clamp = (duty_sum > 14'h0FFF) ? 12'hFFF : duty_sum[11:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_sh <= 3'b000;
      p2_sh <= 3'b000;
    end else begin
      p1_sh <= {p1_sh[1:0], PWM1};
      p2_sh <= {p2_sh[1:0], PWM2};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_cnt <= '0;
      high_cnt   <= '0;
      gap_cnt    <= '0;
      gap_armed  <= 1'b0;
    end else begin
      if (p1_rise)
        period_cnt <= 13'd1;
      else if (period_cnt != CNT_MAX)
        period_cnt <= period_cnt + 13'd1;

      if (p1_rise)
        high_cnt <= 13'd1;
      else if ((state == HIGH) && p1 && (high_cnt != CNT_MAX))
        high_cnt <= high_cnt + 13'd1;

      if (p1_fall | p2_fall)
        gap_cnt <= 4'd0;
      else if (gap_cnt != 4'hF)
        gap_cnt <= gap_cnt + 4'd1;

      // the very first rise after reset has no preceding fall to measure from
      if (p1_rise | p2_rise)
        gap_armed <= 1'b1;
    end
  end

  // A rise takes priority over a coincident timeout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      duty_meas   <= '0;
      period_meas <= '0;
      meas_vld    <= 1'b0;
      stalled     <= 1'b0;
    end else begin
      meas_vld <= 1'b0;
      if (p1_rise) begin
        stalled <= 1'b0;
        if (state == LOW) begin
          duty_meas   <= duty_clamp;
          period_meas <= period_cnt;
          meas_vld    <= 1'b1;
        end
        state <= HIGH;
      end else if (timeout) begin
        state       <= IDLE;
        stalled     <= 1'b1;
        duty_meas   <= p1 ? 12'hFFF : 12'h000;
        period_meas <= CNT_MAX;
        meas_vld    <= 1'b1;
      end else if ((state == HIGH) && p1_fall) begin
        state <= LOW;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overlap_err <= 1'b0;
      gap_err     <= 1'b0;
    end else begin
      overlap_err <= (p1 & p2) | (overlap_err & ~clr_err);
      gap_err     <= gap_evt | (gap_err & ~clr_err);
    end
  end

endmodule

// File: tb/tb_pwm12_decoder.sv
// Self-checking bench for pwm12_decoder: randomized and directed PWM waveforms against a period/duty model.
module tb_pwm12_decoder;

  localparam int NONOV = 44;
  localparam int MINGAP = 8;

  logic        clk = 1'b0;
  logic        rst_n, PWM1, PWM2, clr_err;
  logic [11:0] duty_meas;
  logic [12:0] period_meas;
  logic        meas_vld, overlap_err, gap_err, stalled;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int od[$], op[$], ot[$], rt[$];

  pwm12_decoder dut (
    .clk(clk), .rst_n(rst_n), .PWM1(PWM1), .PWM2(PWM2), .clr_err(clr_err),
    .duty_meas(duty_meas), .period_meas(period_meas), .meas_vld(meas_vld),
    .overlap_err(overlap_err), .gap_err(gap_err), .stalled(stalled)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n === 1'b1 && meas_vld === 1'b1) begin
      od.push_back(int'(duty_meas));
      op.push_back(int'(period_meas));
      ot.push_back(cyc);
    end
  end

  function automatic int model_duty(int h);
    return (h + NONOV > 4095) ? 4095 : h + NONOV;
  endfunction

  task automatic wait_clks(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_q();
    od.delete(); op.delete(); ot.delete(); rt.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; PWM1 = 1'b0; PWM2 = 1'b0; clr_err = 1'b0;
    wait_clks(3);
    rst_n = 1'b1;
    wait_clks(20);
    clear_q();
  endtask

  task automatic drive_cycle(int h1, int da, int h2, int db);
    rt.push_back(cyc);
    PWM1 = 1'b1; wait_clks(h1);
    PWM1 = 1'b0; wait_clks(da);
    PWM2 = 1'b1; wait_clks(h2);
    PWM2 = 1'b0; wait_clks(db);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; PWM1 = 1'b0; PWM2 = 1'b0; clr_err = 1'b0;
    wait_clks(3);
    n_checks++;
    if ({duty_meas, period_meas, meas_vld, overlap_err, gap_err, stalled} !== 30'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got duty=%h period=%h vld=%b ov=%b gap=%b st=%b, expected all zero",
               duty_meas, period_meas, meas_vld, overlap_err, gap_err, stalled);
    end
    rst_n = 1'b1;
    wait_clks(20);
    clear_q();
  endtask

  task automatic test_generator();
    do_reset();
    for (int i = 0; i < 4; i++) drive_cycle(12'h7D4, 12'h02C, 12'h7D4, 12'h02C);
    n_checks++;
    if (od.size() !== 3) begin
      n_fail++; $display("FAIL gen_count: got %0d measurements, expected 3", od.size());
    end
    for (int i = 0; i < od.size() && i < 3; i++) begin
      n_checks++;
      if (od[i] !== 12'h800 || op[i] !== 13'h1000) begin
        n_fail++; $display("FAIL gen_meas[%0d]: got duty=%h period=%h, expected 800/1000", i, od[i], op[i]);
      end
      n_checks++;
      if (ot[i] - rt[i+1] < 3 || ot[i] - rt[i+1] > 4) begin
        n_fail++; $display("FAIL gen_latency[%0d]: got %0d clocks, expected 3..4", i, ot[i] - rt[i+1]);
      end
    end
    for (int i = 1; i < ot.size(); i++) begin
      n_checks++;
      if (ot[i] - ot[i-1] !== 4096) begin
        n_fail++; $display("FAIL gen_interval[%0d]: got %0d, expected 4096", i, ot[i] - ot[i-1]);
      end
    end
    n_checks++;
    if ({overlap_err, gap_err, stalled} !== 3'b000) begin
      n_fail++; $display("FAIL gen_flags: got ov=%b gap=%b st=%b, expected 000", overlap_err, gap_err, stalled);
    end
  endtask

  task automatic test_clamp();
    do_reset();
    for (int i = 0; i < 3; i++) drive_cycle(12'hFF0, 44, 12'h0B8, 44);
    n_checks++;
    if (od.size() !== 2) begin
      n_fail++; $display("FAIL clamp_count: got %0d, expected 2", od.size());
    end
    for (int i = 0; i < od.size() && i < 2; i++) begin
      n_checks++;
      if (od[i] !== 12'hFFF || op[i] !== 13'h1100) begin
        n_fail++; $display("FAIL clamp_meas[%0d]: got duty=%h period=%h, expected fff/1100", i, od[i], op[i]);
      end
    end
  endtask

  task automatic test_random();
    int h1[6], da[6], h2[6], db[6];
    logic exp_gap;
    do_reset();
    exp_gap = 1'b0;
    for (int i = 0; i < 6; i++) begin
      h1[i] = (i == 2) ? $urandom_range(4000, 4200) : $urandom_range(1, 400);
      da[i] = $urandom_range(1, 14);
      h2[i] = $urandom_range(1, 400);
      db[i] = $urandom_range(1, 14);
      if (da[i] < MINGAP) exp_gap = 1'b1;
      if (i < 5 && db[i] < MINGAP) exp_gap = 1'b1;
    end
    for (int i = 0; i < 6; i++) drive_cycle(h1[i], da[i], h2[i], db[i]);
    n_checks++;
    if (od.size() !== 5) begin
      n_fail++; $display("FAIL rand_count: got %0d, expected 5", od.size());
    end
    for (int i = 0; i < od.size() && i < 5; i++) begin
      n_checks++;
      if (od[i] !== model_duty(h1[i]) || op[i] !== h1[i] + da[i] + h2[i] + db[i]) begin
        n_fail++; $display("FAIL rand_meas[%0d]: got duty=%h period=%h, expected %h/%h", i, od[i], op[i],
                           model_duty(h1[i]), h1[i] + da[i] + h2[i] + db[i]);
      end
    end
    n_checks++;
    if (gap_err !== exp_gap || overlap_err !== 1'b0) begin
      n_fail++; $display("FAIL rand_flags: got gap=%b ov=%b, expected gap=%b ov=0", gap_err, overlap_err, exp_gap);
    end
  endtask

  task automatic test_stall();
    do_reset();
    drive_cycle(100, 44, 100, 44);
    drive_cycle(100, 44, 100, 44);
    n_checks++;
    if (od.size() !== 1 || od[0] !== 144 || op[0] !== 288) begin
      n_fail++; $display("FAIL stall_pre: got n=%0d, expected one measurement 90/120", od.size());
    end
    clear_q();
    repeat (210) begin
      PWM2 = 1'b1; wait_clks(20);
      PWM2 = 1'b0; wait_clks(20);
    end
    n_checks++;
    if (stalled !== 1'b1 || od.size() !== 1 || od[0] !== 0 || op[0] !== 13'h1FFF) begin
      n_fail++; $display("FAIL stall_low: got st=%b n=%0d, expected st=1 one meas duty=0 period=1fff", stalled, od.size());
    end
    clear_q();
    PWM1 = 1'b1; wait_clks(10);
    n_checks++;
    if (stalled !== 1'b0 || od.size() !== 0) begin
      n_fail++; $display("FAIL stall_clear1: got st=%b n=%0d, expected 0/0", stalled, od.size());
    end
    wait_clks(8300);
    n_checks++;
    if (stalled !== 1'b1 || od.size() !== 1 || od[0] !== 12'hFFF || op[0] !== 13'h1FFF) begin
      n_fail++; $display("FAIL stall_high: got st=%b n=%0d, expected st=1 one meas duty=fff period=1fff", stalled, od.size());
    end
    clear_q();
    PWM1 = 1'b0; wait_clks(50);
    PWM1 = 1'b1; wait_clks(10);
    n_checks++;
    if (stalled !== 1'b0 || od.size() !== 0) begin
      n_fail++; $display("FAIL stall_clear2: got st=%b n=%0d, expected 0/0", stalled, od.size());
    end
    PWM1 = 1'b0;
  endtask

  task automatic test_overlap();
    do_reset();
    PWM1 = 1'b1; wait_clks(20);
    PWM2 = 1'b1; wait_clks(2);
    PWM2 = 1'b0; wait_clks(10);
    n_checks++;
    if (overlap_err !== 1'b1) begin
      n_fail++; $display("FAIL overlap_set: got %b, expected 1", overlap_err);
    end
    PWM2 = 1'b1; wait_clks(4);
    clr_err = 1'b1; wait_clks(1);
    clr_err = 1'b0; wait_clks(4);
    PWM2 = 1'b0; wait_clks(10);
    n_checks++;
    if (overlap_err !== 1'b1) begin
      n_fail++; $display("FAIL overlap_clr_same: got %b, expected 1", overlap_err);
    end
    clr_err = 1'b1; wait_clks(1);
    clr_err = 1'b0; wait_clks(2);
    n_checks++;
    if (overlap_err !== 1'b0 || gap_err !== 1'b0) begin
      n_fail++; $display("FAIL overlap_clr: got ov=%b gap=%b, expected 0/0", overlap_err, gap_err);
    end
    PWM1 = 1'b0;
  endtask

  task automatic test_gap();
    int dts[4] = '{3, 7, 8, 44};
    logic exp[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    for (int k = 0; k < 4; k++) begin
      do_reset();
      drive_cycle(50, dts[k], 50, 44);
      drive_cycle(50, dts[k], 50, 44);
      n_checks++;
      if (gap_err !== exp[k]) begin
        n_fail++; $display("FAIL gap_dt%0d: got %b, expected %b", dts[k], gap_err, exp[k]);
      end
      clr_err = 1'b1; wait_clks(1);
      clr_err = 1'b0; wait_clks(1);
      n_checks++;
      if (gap_err !== 1'b0) begin
        n_fail++; $display("FAIL gap_clr_dt%0d: got %b, expected 0", dts[k], gap_err);
      end
    end
  endtask

  task automatic test_midreset();
    do_reset();
    drive_cycle(200, 3, 200, 44);
    drive_cycle(200, 3, 200, 44);
    PWM1 = 1'b1; wait_clks(30);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({duty_meas, period_meas, meas_vld, overlap_err, gap_err, stalled} !== 30'd0) begin
      n_fail++; $display("FAIL midreset_outputs: got duty=%h period=%h gap=%b, expected all zero",
                         duty_meas, period_meas, gap_err);
    end
    PWM1 = 1'b0;
    wait_clks(5);
    rst_n = 1'b1;
    wait_clks(20);
    clear_q();
    for (int i = 0; i < 3; i++) drive_cycle(300, 44, 300, 44);
    n_checks++;
    if (od.size() !== 2) begin
      n_fail++; $display("FAIL midreset_count: got %0d, expected 2", od.size());
    end
    for (int i = 0; i < od.size() && i < 2; i++) begin
      n_checks++;
      if (od[i] !== 344 || op[i] !== 688 || gap_err !== 1'b0) begin
        n_fail++; $display("FAIL midreset_meas[%0d]: got duty=%h period=%h gap=%b, expected 158/2b0/0",
                           i, od[i], op[i], gap_err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_generator();
    test_clamp();
    test_random();
    test_stall();
    test_overlap();
    test_gap();
    test_midreset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
